mem_arbiter: RTL and testbench

- Shares one single-port synchronous word RAM between the openmips instruction-fetch port and the load/store (data) port.
- Sits between the core and a unified RAM that replaces the separate instruction ROM.
- Sequences each access through an arbitrate/issue/response FSM and returns a per-port ack.
- Raises a stall request to the pipeline while any port is waiting.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word RAM between the
// instruction-fetch port and the load/store port of the core.
//
// Every access is sequenced IDLE -> ISSUE -> RESP, so the arbiter accepts
// one access every three cycles.
// - In IDLE the arbiter picks a winner and registers the RAM command.
// - In ISSUE the RAM is enabled for one cycle.
// - In RESP the owner receives a one-cycle ack. A load or fetch also gets
//   the RAM read data passed straight through.
//
// Arbitration:
// - Data wins by default.
// - A waiting fetch wins once STARVE_MAX data grants in a row have gone by
//   while it was waiting.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   inst_req_i/addr_i   fetch request and byte address
//   inst_data_o/ack_o   fetched word and one-cycle completion
//   data_req_i/we_i/sel_i/addr_i/wdata_i   load/store request
//   data_rdata_o/ack_o  load data and one-cycle completion
//   ram_ce_o/we_o/sel_o/addr_o/wdata_o     registered RAM command
//   ram_rdata_i         RAM read data, valid the cycle after ram_ce_o
//   stallreq_o          high while any port has an unserved request
module mem_arbiter #(
    parameter int RAM_AW     = 17,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [31:0]       inst_addr_i,
    output logic [31:0]       inst_data_o,
    output logic              inst_ack_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_sel_i,
    input  logic [31:0]       data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic [31:0]       data_rdata_o,
    output logic              data_ack_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_sel_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    output logic              stallreq_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    state_t        state_r;
    owner_t        owner_r;
    logic [CW-1:0] starve_cnt_r;
    logic          load_r;        // the access in flight returns read data
    logic          inst_win_s;
    logic [CW-1:0] starve_next_s;
    logic          unused_addr_s;

    // Byte-lane bits and bits above the RAM window are deliberately ignored.
    assign unused_addr_s = ^{inst_addr_i[31:RAM_AW+2], inst_addr_i[1:0],
                             data_addr_i[31:RAM_AW+2], data_addr_i[1:0]};

    // Arbitration decision and the starve count that results from it.
    always_comb begin
        inst_win_s    = inst_req_i & (~data_req_i | (starve_cnt_r == STARVE_LIM));
        starve_next_s = {CW{1'b0}};
        if (inst_win_s) begin
            starve_next_s = {CW{1'b0}};
        end else if (inst_req_i) begin
            if (starve_cnt_r == STARVE_LIM) begin
                starve_next_s = STARVE_LIM;
            end else begin
                starve_next_s = starve_cnt_r + CW'(1'b1);
            end
        end else begin
            starve_next_s = {CW{1'b0}};
        end
    end

    // Access sequencer: arbitration, RAM command registers and acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_NONE;
            starve_cnt_r <= {CW{1'b0}};
            load_r       <= 1'b0;
            ram_ce_o     <= 1'b0;
            ram_we_o     <= 1'b0;
            ram_sel_o    <= 4'b0000;
            ram_addr_o   <= {RAM_AW{1'b0}};
            ram_wdata_o  <= 32'h0000_0000;
            inst_ack_o   <= 1'b0;
            data_ack_o   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (inst_req_i | data_req_i) begin
                        starve_cnt_r <= starve_next_s;
                        ram_ce_o     <= 1'b1;
                        state_r      <= ST_ISSUE;
                        if (inst_win_s) begin
                            owner_r    <= OWN_INST;
                            load_r     <= 1'b1;
                            ram_we_o   <= 1'b0;
                            ram_sel_o  <= 4'b1111;
                            ram_addr_o <= inst_addr_i[RAM_AW+1:2];
                        end else begin
                            owner_r     <= OWN_DATA;
                            load_r      <= ~data_we_i;
                            ram_we_o    <= data_we_i;
                            ram_sel_o   <= data_sel_i;
                            ram_addr_o  <= data_addr_i[RAM_AW+1:2];
                            ram_wdata_o <= data_wdata_i;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // RAM samples the command on this edge; read data follows in RESP.
                    ram_ce_o   <= 1'b0;
                    ram_we_o   <= 1'b0;
                    inst_ack_o <= (owner_r == OWN_INST);
                    data_ack_o <= (owner_r == OWN_DATA);
                    state_r    <= ST_RESP;
                end
                ST_RESP: begin
                    inst_ack_o <= 1'b0;
                    data_ack_o <= 1'b0;
                    owner_r    <= OWN_NONE;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    ram_ce_o   <= 1'b0;
                    ram_we_o   <= 1'b0;
                    inst_ack_o <= 1'b0;
                    data_ack_o <= 1'b0;
                    owner_r    <= OWN_NONE;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data is passed through from the RAM during the owner's ack cycle only.
    always_comb begin
        if (inst_ack_o & load_r) begin
            inst_data_o = ram_rdata_i;
        end else begin
            inst_data_o = 32'h0000_0000;
        end
        if (data_ack_o & load_r) begin
            data_rdata_o = ram_rdata_i;
        end else begin
            data_rdata_o = 32'h0000_0000;
        end
    end

    // Stall the pipeline while any port still waits for its ack.
    always_comb begin
        stallreq_o = (inst_req_i & ~inst_ack_o) | (data_req_i & ~data_ack_o);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_we;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_sel;
    logic [31:0] inst_data, data_rdata, ram_wdata, ram_rdata;
    logic        inst_ack, data_ack, ram_ce, ram_we, stallreq;
    logic [3:0]  ram_sel;
    logic [16:0] ram_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    mem_arbiter #(.RAM_AW(17), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr),
        .inst_data_o(inst_data), .inst_ack_o(inst_ack),
        .data_req_i(data_req), .data_we_i(data_we), .data_sel_i(data_sel),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_rdata_o(data_rdata), .data_ack_o(data_ack),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_sel_o(ram_sel),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata), .stallreq_o(stallreq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bench RAM: synchronous single-port word memory with byte enables
    logic [31:0] ram_mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;
        ram_mem[4]  = 32'h3401_1100;
        ram_mem[8]  = 32'h1122_3344;
        ram_mem[12] = 32'hDEAD_BEEF;
        ram_rdata   = 32'h0;
        forever begin
            @(posedge clk);
            if (ram_ce === 1'b1) begin
                ram_rdata <= ram_mem[ram_addr[9:0]];
                if (ram_we === 1'b1)
                    for (int b = 0; b < 4; b++)
                        if (ram_sel[b]) ram_mem[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: access timeline by grant timestamp, plus its own memory image
    logic [31:0] mmem [0:1023];
    initial begin : model
        bit          busy;
        bit          m_inst, m_we;
        int          gcyc, starve;
        logic [3:0]  m_sel;
        logic [16:0] m_addr;
        logic [31:0] m_wd, m_rd;
        logic        e_ce, e_iack, e_dack;
        logic [31:0] e_idat, e_ddat;
        for (int i = 0; i < 1024; i++) mmem[i] = 32'h0;
        mmem[4]  = 32'h3401_1100;
        mmem[8]  = 32'h1122_3344;
        mmem[12] = 32'hDEAD_BEEF;
        busy = 0; starve = 0; gcyc = 0; m_inst = 0; m_we = 0;
        m_sel = 4'h0; m_addr = 17'h0; m_wd = 32'h0; m_rd = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; starve = 0;
                chk("m_rst_ce", 32'(ram_ce), 32'h0);
                chk("m_rst_we", 32'(ram_we), 32'h0);
                chk("m_rst_sel", 32'(ram_sel), 32'h0);
                chk("m_rst_addr", 32'(ram_addr), 32'h0);
                chk("m_rst_wdata", ram_wdata, 32'h0);
                chk("m_rst_acks", {30'h0, inst_ack, data_ack}, 32'h0);
                chk("m_rst_rdata", inst_data | data_rdata, 32'h0);
                chk("m_rst_stall", 32'(stallreq), 32'h0);
            end else begin
                if (busy && cyc >= gcyc + 3) busy = 0;
                e_ce   = busy && (cyc == gcyc + 1);
                e_iack = busy && (cyc == gcyc + 2) && m_inst;
                e_dack = busy && (cyc == gcyc + 2) && !m_inst;
                e_idat = e_iack ? m_rd : 32'h0;
                e_ddat = (e_dack && !m_we) ? m_rd : 32'h0;
                chk("m_ce", 32'(ram_ce), 32'(e_ce));
                chk("m_we", 32'(ram_we), 32'(e_ce && m_we));
                chk("m_inst_ack", 32'(inst_ack), 32'(e_iack));
                chk("m_data_ack", 32'(data_ack), 32'(e_dack));
                chk("m_inst_data", inst_data, e_idat);
                chk("m_data_rdata", data_rdata, e_ddat);
                chk("m_stall", 32'(stallreq),
                    32'((inst_req && !e_iack) || (data_req && !e_dack)));
                if (e_ce) begin
                    chk("m_addr", 32'(ram_addr), 32'(m_addr));
                    chk("m_sel", 32'(ram_sel), 32'(m_sel));
                    if (m_we) chk("m_wdata", ram_wdata, m_wd);
                    m_rd = mmem[m_addr[9:0]];
                    if (m_we)
                        for (int b = 0; b < 4; b++)
                            if (m_sel[b]) mmem[m_addr[9:0]][8*b +: 8] = m_wd[8*b +: 8];
                end
                // Arbitration for the coming edge, only when nothing is in flight
                if (!busy && (inst_req || data_req)) begin
                    busy = 1; gcyc = cyc;
                    if (inst_req && (!data_req || starve == SMAX)) begin
                        m_inst = 1; m_we = 0; m_sel = 4'hF;
                        m_addr = inst_addr[18:2]; starve = 0;
                    end else begin
                        m_inst = 0; m_we = data_we; m_sel = data_sel;
                        m_addr = data_addr[18:2]; m_wd = data_wdata;
                        starve = inst_req ? ((starve == SMAX) ? SMAX : starve + 1) : 0;
                    end
                end
            end
        end
    end

    task automatic data_acc(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] wd, output int lat, output logic [31:0] rd,
                            output logic we_seen);
        @(posedge clk); #1;
        data_req = 1'b1; data_we = we; data_sel = sel; data_addr = addr; data_wdata = wd;
        lat = -1; rd = 32'h0; we_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ram_ce) we_seen = ram_we;
            if (data_ack) begin lat = k; rd = data_rdata; break; end
        end
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL data_timeout: got no ack required ack within 20 cycles");
        end
        @(posedge clk); #1;
        data_req = 1'b0; data_we = 1'b0;
    endtask

    initial begin : stim
        int          lat, d_at, i_at, n_ack;
        logic [31:0] rd;
        logic        ws;
        byte         seq [6];
        byte         exp_seq [6];
        exp_seq[0] = "D"; exp_seq[1] = "D"; exp_seq[2] = "D";
        exp_seq[3] = "D"; exp_seq[4] = "I"; exp_seq[5] = "D";
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0; data_sel = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle: nothing happens for 10 cycles
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_ce", 32'(ram_ce), 32'h0);
            chk("idle_stall", {29'h0, stallreq, inst_ack, data_ack}, 32'h0);
        end

        // Fetch of word 4
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'h0000_0010;
        @(negedge clk); chk("f_stall_T", 32'(stallreq), 32'h1);
        @(negedge clk); chk("f_ce_T1", 32'(ram_ce), 32'h1);
        chk("f_addr_T1", 32'(ram_addr), 32'h4);
        chk("f_stall_T1", 32'(stallreq), 32'h1);
        @(negedge clk); chk("f_ack_T2", 32'(inst_ack), 32'h1);
        chk("f_data_T2", inst_data, 32'h3401_1100);
        chk("f_stall_T2", 32'(stallreq), 32'h0);
        @(posedge clk); #1; inst_req = 1'b0;

        // Partial store then load-back
        data_acc(1'b1, 4'b0011, 32'h20, 32'hAABB_CCDD, lat, rd, ws);
        chk("st_we_issue", 32'(ws), 32'h1);
        chk("st_lat", 32'(lat), 32'h2);
        data_acc(1'b0, 4'b1111, 32'h20, 32'h0, lat, rd, ws);
        chk("ld_lat", 32'(lat), 32'h2);
        chk("ld_data", rd, 32'h1122_CCDD);

        // Both requests together: data first, instruction three cycles later
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'h10; data_req = 1'b1; data_we = 1'b0;
        data_addr = 32'h20; data_sel = 4'hF;
        d_at = -1; i_at = -1;
        for (int k = 0; k < 12 && (d_at < 0 || i_at < 0); k++) begin
            @(negedge clk);
            if (data_ack && d_at < 0) d_at = k;
            if (inst_ack && i_at < 0) i_at = k;
            if (data_ack || inst_ack) begin
                @(posedge clk); #1;
                if (d_at >= 0) data_req = 1'b0;
                if (i_at >= 0) inst_req = 1'b0;
            end
        end
        chk("both_data_ack_at", 32'(d_at), 32'd2);
        chk("both_inst_ack_at", 32'(i_at), 32'd5);

        // Starvation bound: data held high, fetch waits four grants
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'h10; data_req = 1'b1; data_we = 1'b0;
        data_addr = 32'h20;
        n_ack = 0;
        for (int k = 0; k < 40 && n_ack < 6; k++) begin
            @(negedge clk);
            if (data_ack) begin seq[n_ack] = "D"; n_ack++; end
            else if (inst_ack) begin
                seq[n_ack] = "I"; n_ack++;
                @(posedge clk); #1; inst_req = 1'b0;
            end
        end
        chk("starve_acks", 32'(n_ack), 32'd6);
        for (int i = 0; i < 6; i++) chk("starve_order", 32'(seq[i]), 32'(exp_seq[i]));
        @(posedge clk); #1; data_req = 1'b0; inst_req = 1'b0;

        // Request dropped during ISSUE still completes
        @(posedge clk); #1; inst_req = 1'b1; inst_addr = 32'h10;
        @(posedge clk); #1; inst_req = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("drop_ack", 32'(inst_ack), 32'h1);
        chk("drop_stall", 32'(stallreq), 32'h0);
        @(negedge clk); chk("drop_idle_ce", 32'(ram_ce), 32'h0);

        // Reset in the middle of a store's ISSUE cycle
        @(posedge clk); #1;
        data_req = 1'b1; data_we = 1'b1; data_sel = 4'hF; data_addr = 32'h30; data_wdata = 32'h0;
        @(posedge clk); #1;
        chk("rst_pre_ce", 32'(ram_ce), 32'h1);
        #1 rst = 1'b1; data_req = 1'b0; data_we = 1'b0;
        #1;
        chk("rst_ce", 32'(ram_ce), 32'h0);
        chk("rst_we", 32'(ram_we), 32'h0);
        chk("rst_addr_sel", {11'h0, ram_addr, ram_sel}, 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        chk("rst_stall", 32'(stallreq), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ram_kept", ram_mem[12], 32'hDEAD_BEEF);
        data_acc(1'b0, 4'hF, 32'h30, 32'h0, lat, rd, ws);
        chk("post_rst_lat", 32'(lat), 32'h2);
        chk("post_rst_data", rd, 32'hDEAD_BEEF);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
